// File: rtl/mult_div_unit.sv
// Sequential signed multiply/divide: radix-2 Booth multiply and restoring divide on
// magnitudes, one bit per clock, results presented on HI/LO.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             MULT_OP,
    input  logic             DIV_OP,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int PW = 2 * WIDTH + 2;

    typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN, FINISH} state_t;

    state_t           state_q, state_d;
    logic             mop_q, dop_q;
    logic [PW-1:0]    prod_q, prod_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] rem_q, rem_d, dvd_q, dvd_d, dvs_q, dvs_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             q_neg_q, q_neg_d, r_neg_q, r_neg_d, dz_q, dz_d;

    logic             mul_start, div_start, qbit;
    logic [WIDTH:0]   acc, acc_new, mc_ext, rem_sh;
    logic [WIDTH-1:0] trial, rem_step, dvd_step;
    logic [PW-1:0]    prod_step;

    assign mul_start = MULT_OP & ~mop_q;
    assign div_start = DIV_OP & ~dop_q;

    // Accumulator is WIDTH+1 bits so that subtracting the most negative
    // multiplicand cannot overflow; the product is still bits [2W:1].
    always_comb begin
        mc_ext = {mcand_q[WIDTH-1], mcand_q};
        acc    = prod_q[PW-1:WIDTH+1];
        case (prod_q[1:0])
            2'b01:   acc_new = acc + mc_ext;
            2'b10:   acc_new = acc - mc_ext;
            default: acc_new = acc;
        endcase
        prod_step = {acc_new[WIDTH], acc_new, prod_q[WIDTH:1]};

        rem_sh   = {rem_q, dvd_q[WIDTH-1]};
        qbit     = (rem_sh >= {1'b0, dvs_q});
        trial    = rem_sh[WIDTH-1:0] - dvs_q;
        rem_step = qbit ? trial : rem_sh[WIDTH-1:0];
        dvd_step = {dvd_q[WIDTH-2:0], qbit};
    end

    always_comb begin
        state_d = state_q;
        prod_d  = prod_q;
        mcand_d = mcand_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        dz_d    = dz_q;
        case (state_q)
            IDLE: begin
                if (mul_start) begin
                    mcand_d = A;
                    prod_d  = {{(WIDTH + 1){1'b0}}, B, 1'b0};
                    cnt_d   = CW'(WIDTH);
                    dz_d    = 1'b0;
                    state_d = MUL_RUN;
                end else if (div_start) begin
                    if (B == '0) begin
                        dz_d    = 1'b1;
                        state_d = FINISH;
                    end else begin
                        dvd_d   = A[WIDTH-1] ? -A : A;
                        dvs_d   = B[WIDTH-1] ? -B : B;
                        q_neg_d = A[WIDTH-1] ^ B[WIDTH-1];
                        r_neg_d = A[WIDTH-1];
                        rem_d   = '0;
                        cnt_d   = CW'(WIDTH);
                        dz_d    = 1'b0;
                        state_d = DIV_RUN;
                    end
                end
            end
            // Results are captured on the last step so they are visible in FINISH.
            MUL_RUN: begin
                prod_d = prod_step;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    hi_d    = prod_step[2*WIDTH:WIDTH+1];
                    lo_d    = prod_step[WIDTH:1];
                    state_d = FINISH;
                end
            end
            DIV_RUN: begin
                rem_d = rem_step;
                dvd_d = dvd_step;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    lo_d    = q_neg_q ? -dvd_step : dvd_step;
                    hi_d    = r_neg_q ? -rem_step : rem_step;
                    state_d = FINISH;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            mop_q   <= 1'b0;
            dop_q   <= 1'b0;
            prod_q  <= '0;
            mcand_q <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            mop_q   <= MULT_OP;
            dop_q   <= DIV_OP;
            prod_q  <= prod_d;
            mcand_q <= mcand_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            dz_q    <= dz_d;
        end
    end

    assign HI       = hi_q;
    assign LO       = lo_q;
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == FINISH);
    assign div_zero = dz_q;

endmodule
